flop_force_sched: RTL

//  Schedules asynchronous force (clear/preset) operations onto a shared bank of WIDTH D flops

---
 rtl/flop_ctrl_pkg.sv | 19 +
 rtl/flop_force_sched_rr_arbiter.sv | 30 +++
 rtl/flop_force_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/flop_ctrl_pkg.sv
// Shared encodings for the flop force scheduler: op codes and FSM states.
package flop_ctrl_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORCE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Op 11 also clears: the low bit alone selects clear over preset.
  function automatic logic op_is_clear(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/flop_force_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/flop_force_sched.sv
// Arbitrates clear/preset force requests onto a shared flop bank and times
// the hold/release sequence; all outputs come straight from flops.
module flop_force_sched
  import flop_ctrl_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_mask,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      clear_n,
  output logic [WIDTH-1:0]      preset_n,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYC + 1);

  logic [NREQ-1:0][1:0]       op_v;
  logic [NREQ-1:0][WIDTH-1:0] mask_v;
  assign op_v   = req_op;
  assign mask_v = req_mask;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [IW-1:0]   ptr, ptr_d;
  logic [IW-1:0]   widx, widx_d;
  logic [NREQ-1:0] gnt_d, done_d;
  logic [WIDTH-1:0] clr_d, set_d;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [1:0]      win_op;
  logic [WIDTH-1:0] win_mask;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign win_op   = op_v[arb_idx];
  assign win_mask = mask_v[arb_idx];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ptr_d   = ptr;
    widx_d  = widx;
    gnt_d   = '0;
    done_d  = '0;
    clr_d   = clear_n;
    set_d   = preset_n;
    unique case (state)
      ST_IDLE: begin
        if (arb_any) begin
          ptr_d  = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
          widx_d = arb_idx;
          gnt_d  = arb_gnt;
          if (win_op == OP_NOP) begin
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_FORCE;
            cnt_d   = CW'(HOLD_CYC - 1);
            // Only one pin group is ever driven, so clear and preset never overlap.
            if (op_is_clear(win_op)) clr_d = ~win_mask;
            else                     set_d = ~win_mask;
          end
        end
      end
      ST_FORCE: begin
        if (cnt == '0) begin
          state_d = ST_RELEASE;
          clr_d   = '1;
          set_d   = '1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ST_RELEASE: begin
        state_d      = ST_IDLE;
        done_d[widx] = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        clr_d   = '1;
        set_d   = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ptr      <= '0;
      widx     <= '0;
      gnt      <= '0;
      done     <= '0;
      clear_n  <= '1;
      preset_n <= '1;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ptr      <= ptr_d;
      widx     <= widx_d;
      gnt      <= gnt_d;
      done     <= done_d;
      clear_n  <= clr_d;
      preset_n <= set_d;
      busy     <= (state_d != ST_IDLE);
    end
  end

endmodule
